// File: rtl/inst_fetch_pkg.sv
// Shared configuration for the instruction-fetch stage.
// Holds the address/instruction widths, the all-zero word, the reset
// polarity, the pc reset value and the fetch FSM state encoding.
package inst_fetch_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;

    localparam logic [InstLen-1:0] ZERO_WORD   = '0;
    localparam logic               ResetEnable = 1'b1;

    localparam logic [AddrLen-1:0] PC_RESET = '0;
    localparam logic [AddrLen-1:0] PC_STEP  = 32'd4;

    // IDLE: free to issue a request; WAIT: one request outstanding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage.
// Issues one instruction-memory read at a time from an internal pc and
// presents the returned word as a registered bundle {if_valid, if_pc,
// if_inst} toward the IF/ID register. A redirect (jump_i) reloads the pc,
// flushes the bundle and, if a read is still in flight, marks its data to
// be thrown away when it arrives.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall_i         downstream cannot take the bundle this cycle
//   jump_i          one-cycle redirect request, target on jump_addr_i
//   mem_req_o       read request, address on mem_addr_o
//   mem_ready_i     memory accepts the request this cycle
//   mem_rvalid_i    one-cycle read-data pulse, data on mem_rdata_i
//   if_pc, if_inst  fetched bundle, live while if_valid is high
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                jump_i,
    input  logic [AddrLen-1:0]  jump_addr_i,
    output logic                mem_req_o,
    output logic [AddrLen-1:0]  mem_addr_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [InstLen-1:0]  mem_rdata_i,
    output logic [AddrLen-1:0]  if_pc,
    output logic [InstLen-1:0]  if_inst,
    output logic                if_valid
);

    fetch_state_e       r_state;
    logic [AddrLen-1:0] r_pc;
    logic               r_discard;
    logic               r_if_valid;
    logic [AddrLen-1:0] r_if_pc;
    logic [InstLen-1:0] r_if_inst;

    logic w_in_reset;
    logic w_req;
    logic w_consume;

    assign w_in_reset = (rst == ResetEnable);

    // A new request is only worthwhile when the output register will be free
    // by the time data returns: either empty now or drained this cycle.
    assign w_req = !w_in_reset && (r_state == ST_IDLE) && !jump_i &&
                   (!r_if_valid || !stall_i);

    assign w_consume = r_if_valid && !stall_i;

    assign mem_req_o  = w_req;
    assign mem_addr_o = r_pc;
    assign if_valid   = r_if_valid;
    assign if_pc      = r_if_pc;
    assign if_inst    = r_if_inst;

    always_ff @(posedge clk) begin
        if (w_in_reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= PC_RESET;
            r_discard  <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= ZERO_WORD;
            r_if_inst  <= ZERO_WORD;
        end else begin
            // Default: a consumed bundle empties the output register; a load
            // below on the same edge overrides this.
            if (w_consume) begin
                r_if_valid <= 1'b0;
            end

            if (jump_i) begin
                // Redirect wins over stall and over any returning data.
                r_pc       <= jump_addr_i;
                r_if_valid <= 1'b0;
                if (r_state == ST_WAIT) begin
                    if (mem_rvalid_i) begin
                        // Stale data arrives right now: drop it and go idle,
                        // nothing left in flight to discard later.
                        r_state   <= ST_IDLE;
                        r_discard <= 1'b0;
                    end else begin
                        r_discard <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_req && mem_ready_i) begin
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_rvalid_i) begin
                            r_state <= ST_IDLE;
                            if (r_discard) begin
                                r_discard <= 1'b0;
                            end else begin
                                r_if_valid <= 1'b1;
                                r_if_pc    <= r_pc;
                                r_if_inst  <= mem_rdata_i;
                                r_pc       <= r_pc + PC_STEP;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i  = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } bundle_t;

    bundle_t sb[$];
    bundle_t chk_b;

    // Memory / fetch reference model state
    logic [31:0] exp_addr    = 32'h0;
    bit          outstanding = 1'b0;
    bit          m_discard   = 1'b0;
    int          cnt         = 0;
    logic [31:0] pend_data   = 32'h0;
    int          lat         = 1;
    bit          resp_en     = 1'b1;
    bit          late_rv     = 1'b0;
    bit          data_mode   = 1'b0;
    int          n_bundles   = 0;

    // Pre-edge snapshot used by the negedge bundle checker
    bit          p_valid = 1'b0;
    bit          p_cons  = 1'b0;
    bit          p_jump  = 1'b0;
    bit          p_rst   = 1'b0;
    logic [31:0] h_pc    = 32'h0;
    logic [31:0] h_inst  = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit mode);
        if (mode) return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
        return 32'h00000013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Edge monitor: request/response bookkeeping and scoreboard pushes
    always @(posedge clk) begin
        p_valid = if_valid;
        p_cons  = if_valid && !stall_i;
        p_jump  = jump_i;
        p_rst   = rst;
        h_pc    = if_pc;
        h_inst  = if_inst;
        if (rst) begin
            outstanding = 1'b0;
            m_discard   = 1'b0;
            exp_addr    = 32'h0;
            sb.delete();
        end else begin
            if (mem_req_o) check_eq("one_outstanding", {31'b0, outstanding}, 32'h0);
            if (outstanding && mem_rvalid_i) begin
                outstanding = 1'b0;
                if (jump_i || m_discard) void'(sb.pop_back());
                else exp_addr = exp_addr + 32'd4;
                m_discard = 1'b0;
            end else if (outstanding) begin
                if (jump_i) m_discard = 1'b1;
                if (cnt > 0) cnt--;
            end
            if (jump_i) exp_addr = jump_addr_i;
            if (mem_req_o && mem_ready_i) begin
                check_eq("req_addr", mem_addr_o, exp_addr);
                pend_data = mem_word(exp_addr, data_mode);
                sb.push_back({exp_addr, pend_data});
                outstanding = 1'b1;
                cnt = lat - 1;
            end
        end
    end

    // Memory response driver
    always @(negedge clk) begin
        mem_rvalid_i = (outstanding && cnt == 0 && resp_en) || late_rv;
        mem_rdata_i  = late_rv ? 32'hDEADBEEF : pend_data;
    end

    // Output bundle checker
    always @(negedge clk) begin
        if (p_rst) begin
            check_eq("rst_valid", {31'b0, if_valid}, 32'h0);
            check_eq("rst_pc", if_pc, 32'h0);
            check_eq("rst_inst", if_inst, 32'h0);
        end else if (p_jump) begin
            check_eq("flush_valid", {31'b0, if_valid}, 32'h0);
        end else if (if_valid && (!p_valid || p_cons)) begin
            n_bundles++;
            if (sb.size() == 0) begin
                check_eq("unexpected_bundle", if_pc, 32'hFFFF_FFFF);
            end else begin
                chk_b = sb.pop_front();
                check_eq("bundle_pc", if_pc, chk_b.pc);
                check_eq("bundle_inst", if_inst, chk_b.inst);
            end
        end else if (p_valid && !p_cons) begin
            check_eq("hold_valid", {31'b0, if_valid}, 32'h1);
            check_eq("hold_pc", if_pc, h_pc);
            check_eq("hold_inst", if_inst, h_inst);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_bundles(input int target);
        int budget;
        budget = 200;
        while (n_bundles < target && budget > 0) begin
            tick();
            budget--;
        end
        check_eq("bundle_wait", n_bundles, target);
    endtask

    initial begin
        rst         = 1'b1;
        stall_i     = 1'b0;
        jump_i      = 1'b0;
        jump_addr_i = 32'h0;
        mem_ready_i = 1'b1;

        // Reset: no request even though memory is ready
        tick();
        tick();
        check_eq("req_in_rst", {31'b0, mem_req_o}, 32'h0);
        rst = 1'b0;
        #1;
        check_eq("reset_addr", mem_addr_o, 32'h0);
        check_eq("reset_req", {31'b0, mem_req_o}, 32'h1);

        // Sequential fetch 0x0, 0x4
        wait_bundles(2);
        check_eq("pc_before_stall", if_pc, 32'h4);

        // Stall three cycles while 0x4 is held
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            stall_i = 1'b1;
            #1;
            check_eq("stall_no_req", {31'b0, mem_req_o}, 32'h0);
            tick();
        end
        stall_i = 1'b0;
        #1;
        check_eq("release_req", {31'b0, mem_req_o}, 32'h1);
        check_eq("release_addr", mem_addr_o, 32'h8);

        // Jump to 0x100 while waiting on 0x8 (data returns later, dropped)
        tick();
        jump_i      = 1'b1;
        jump_addr_i = 32'h100;
        tick();
        jump_i = 1'b0;
        lat    = 1;
        wait_bundles(3);
        lat = 2;

        // Jump to 0x200 in the same cycle as rvalid
        begin
            int budget;
            budget = 50;
            while (!mem_rvalid_i && budget > 0) begin
                tick();
                budget--;
            end
            check_eq("rvalid_seen", {31'b0, mem_rvalid_i}, 32'h1);
        end
        jump_i      = 1'b1;
        jump_addr_i = 32'h200;
        tick();
        jump_i = 1'b0;
        wait_bundles(4);

        // Jump while stalled with a live bundle
        stall_i     = 1'b1;
        jump_i      = 1'b1;
        jump_addr_i = 32'h300;
        tick();
        jump_i = 1'b0;
        check_eq("jump_stall_flush", {31'b0, if_valid}, 32'h0);
        tick();
        stall_i   = 1'b0;
        lat       = 1;
        data_mode = 1'b1;
        wait_bundles(5);

        // Wraparound at the top of the address space
        jump_i      = 1'b1;
        jump_addr_i = 32'hFFFF_FFFC;
        tick();
        jump_i = 1'b0;
        wait_bundles(7);

        // Reset while a request is outstanding, then a late rvalid
        resp_en = 1'b0;
        begin
            int budget;
            budget = 20;
            while (!outstanding && budget > 0) begin
                tick();
                budget--;
            end
            check_eq("outstanding_before_rst", {31'b0, outstanding}, 32'h1);
        end
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        mem_ready_i = 1'b0;
        late_rv     = 1'b1;
        tick();
        late_rv = 1'b0;
        tick();
        tick();
        check_eq("late_rvalid_valid", {31'b0, if_valid}, 32'h0);
        check_eq("after_rst_addr", mem_addr_o, 32'h0);
        mem_ready_i = 1'b1;
        resp_en     = 1'b1;
        wait_bundles(10);

        // Drain
        mem_ready_i = 1'b0;
        repeat (6) tick();
        check_eq("sb_drained", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
